bcd_addsub_seq: RTL and testbench
=================================

Name: bcd_addsub_seq

Overview:
- Multi-digit packed-BCD adder/subtractor. Operands are accepted with a valid/ready handshake and processed digit-serially, least significant digit first, one digit per clock.
- Each digit is corrected in decimal: a raw digit sum above 9 emits the sum minus 10 and a carry of 1.
- Subtraction uses the nine's complement of B plus a carry-in.
- Flags invalid (non-BCD) input digits.
- Sits between operand registers and result consumers as the area-lean replacement for a chain of combinational single-digit BCD adders.

Parameters:
- NDIGITS, 4, number of BCD digits per operand (>=1); data width is 4*NDIGITS.
- CNT_W, $clog2(NDIGITS)+1, width of the internal digit counter; derived, do not override.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  4*NDIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- b  in  4*NDIGITS  operand B, packed BCD.
- sub  in  1  0 = A+B, 1 = A-B.
- cin  in  1  carry-in when sub=0; borrow-in when sub=1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  4*NDIGITS  packed BCD result.
- cout  out  1  decimal carry-out (add); 1 = no borrow, i.e. A-B-cin >= 0 (sub).
- err  out  1  at least one digit of a or b was > 9.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, sum=0, cout=0, err=0, counter=0, carry=0. in_ready=1 once out of reset. Reset mid-operation aborts the operation with no output.
- States IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - When in_valid&in_ready at an edge:
    - latch a, b and sub;
    - carry <= sub ? ~cin : cin;
    - clear err and the sum register;
    - set counter=0;
    - go to RUN.
- RUN: in_ready=0, out_valid=0. Each edge processes digit i = counter:
  - bd = sub ? (9 - b_i) : b_i, computed in 4 bits.
  - raw = a_i + bd + carry, computed in 5 bits.
  - If raw > 9: digit = raw + 6 (low 4 bits), carry <= 1. Else digit = raw, carry <= 0.
  - Write sum digit i.
  - err <= err | (a_i > 9) | (b_i > 9).
  - counter++.
  - On the edge that processes digit NDIGITS-1: cout <= final carry, state -> DONE.
- DONE: out_valid=1; sum, cout and err are held stable. in_ready=0.
  - On an edge with out_ready=1: out_valid drops, state -> IDLE.
  - No new operand is accepted in the same edge.
- Latency: if accepted at edge 0, out_valid is high after edge NDIGITS.
- Throughput: one operation per NDIGITS+2 cycles when out_ready is held high.
- Subtract result when cout=0: the 10^NDIGITS complement of B-A+cin (wrap-around). No sign/magnitude conversion is done.
- Invalid digits: arithmetic still runs with the formulas above. The result value is unspecified, but err=1 and cout still follow the carry logic; the bench checks only err.
- in_valid while busy is ignored; the operand must be held by the producer until in_ready.
- Inputs a, b, sub and cin are sampled only on the accept edge. Changes after accept do not affect the result.
- NDIGITS=1: RUN lasts exactly one cycle.

Test Plan:
- NDIGITS=4, a=0x1234, b=0x8766, sub=0, cin=0 -> sum=0x0000, cout=1, err=0; out_valid rises exactly 4 edges after accept.
- a=0x0999, b=0x0000, sub=0, cin=1 -> sum=0x1000, cout=0 (carry ripples through three digits).
- a=0x5000, b=0x1234, sub=1, cin=0 -> sum=0x3766, cout=1. Then a=0x1234, b=0x5000, sub=1 -> sum=0x6234, cout=0. Then a=0x0000, b=0x0000, sub=1, cin=1 -> sum=0x9999, cout=0.
- a=0x12A4, b=0x0001, sub=0 -> err=1 with out_valid. The next operation, a=0x0001, b=0x0001 -> err=0, sum=0x0002.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE one edge later, then the next operand is accepted.
- Assert rst_n=0 asynchronously mid-RUN (after digit 1) -> outputs zero immediately, in_ready=1 after release. A fresh 0x0001+0x0001 then completes correctly with sum=0x0002.

Source files
------------

// File: rtl/bcd_addsub_seq_if.sv
// Operand/result handshake bundle for the digit-serial BCD adder/subtractor.
// master = producer/consumer side, slave = the arithmetic block.
interface bcd_addsub_seq_if #(
  parameter int NDIGITS = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NDIGITS-1:0]   a;
  logic [4*NDIGITS-1:0]   b;
  logic                   sub;
  logic                   cin;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NDIGITS-1:0]   sum;
  logic                   cout;
  logic                   err;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, err
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, err
  );
endinterface

// File: rtl/bcd_addsub_seq.sv
// Digit-serial packed-BCD adder/subtractor, LSD first, one digit per clock.
// Operands shift right each RUN cycle; result digits shift in from the top.
module bcd_addsub_seq #(
  parameter int NDIGITS = 4,
  parameter int CNT_W   = $clog2(NDIGITS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_addsub_seq_if.slave  bus
);
  localparam int W = 4 * NDIGITS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [W-1:0]     a_q, b_q, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sub_q, carry_q, cout_q, err_q;
  logic             in_ready_q, out_valid_q;

  logic [3:0]       a_dig, b_dig, bd, dig_d;
  logic [4:0]       raw;
  logic             carry_d, bad_d;

  // Single-digit decimal slice working on the current low nibble.
  always_comb begin
    a_dig   = a_q[3:0];
    b_dig   = b_q[3:0];
    bd      = sub_q ? (4'd9 - b_dig) : b_dig;
    raw     = {1'b0, a_dig} + {1'b0, bd} + {4'd0, carry_q};
    carry_d = (raw > 5'd9);
    dig_d   = carry_d ? (raw[3:0] + 4'd6) : raw[3:0];
    bad_d   = (a_dig > 4'd9) | (b_dig > 4'd9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            sub_q      <= bus.sub;
            carry_q    <= bus.sub ? ~bus.cin : bus.cin;
            err_q      <= 1'b0;
            sum_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          // After NDIGITS shifts digit 0 lands in bits [3:0].
          sum_q   <= (sum_q >> 4) | (W'(dig_d) << (W - 4));
          carry_q <= carry_d;
          err_q   <= err_q | bad_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NDIGITS - 1)) begin
            cout_q      <= carry_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Self-checking bench: directed cases plus random operands against a
// decimal-integer reference model.
module tb_bcd_addsub_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  bcd_addsub_seq_if #(.NDIGITS(N)) bus ();

  bcd_addsub_seq #(.NDIGITS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned bcd2int(input logic [W-1:0] v);
    longint unsigned r;
    r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint unsigned v);
    logic [W-1:0] r;
    longint unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Plain decimal arithmetic modulo 10^N.
  task automatic model(input logic [W-1:0] a, b, input logic s, c,
                       output logic [W-1:0] es, output logic ec, output logic ee);
    longint m, r;
    m = 1;
    for (int i = 0; i < N; i++) m = m * 10;
    if (!s) r = longint'(bcd2int(a)) + longint'(bcd2int(b)) + longint'(c);
    else    r = longint'(bcd2int(a)) - longint'(bcd2int(b)) - longint'(c);
    if (!s) ec = (r >= m);
    else    ec = (r >= 0);
    if (r < 0) r = r + m;
    es = int2bcd(longint'(r % m));
    ee = has_bad(a) | has_bad(b);
  endtask

  task automatic run_op(input logic [W-1:0] a, b, input logic s, c,
                        output logic [W-1:0] so, output logic co, eo);
    int t;
    int lat;
    bus.a = a; bus.b = b; bus.sub = s; bus.cin = c; bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk("accept_timeout", 64'(t < 50), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Scramble inputs after accept; they must not affect the result.
    bus.a = W'($urandom); bus.b = W'($urandom); bus.sub = ~s; bus.cin = ~c;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), 64'(N));
    so = bus.sum; co = bus.cout; eo = bus.err;
    if (bus.out_ready) begin
      @(posedge clk); #1;
      chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
      chk("drain_in_ready", 64'(bus.in_ready), 64'd1);
    end
  endtask

  task automatic op_check(input string tag, input logic [W-1:0] a, b, input logic s, c);
    logic [W-1:0] so, es;
    logic co, eo, ec, ee;
    model(a, b, s, c, es, ec, ee);
    run_op(a, b, s, c, so, co, eo);
    chk({tag, "_err"}, 64'(eo), 64'(ee));
    if (!ee) begin
      chk({tag, "_sum"}, 64'(so), 64'(es));
      chk({tag, "_cout"}, 64'(co), 64'(ec));
    end
  endtask

  initial begin
    logic [W-1:0] so, ra, rb, bp_sum;
    logic co, eo, bp_cout;
    n_chk = 0; n_fail = 0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed cases with hand-computed expectations.
    run_op(16'h1234, 16'h8766, 1'b0, 1'b0, so, co, eo);
    chk("d1_sum", 64'(so), 64'h0000); chk("d1_cout", 64'(co), 64'd1); chk("d1_err", 64'(eo), 64'd0);
    run_op(16'h0999, 16'h0000, 1'b0, 1'b1, so, co, eo);
    chk("d2_sum", 64'(so), 64'h1000); chk("d2_cout", 64'(co), 64'd0);
    run_op(16'h5000, 16'h1234, 1'b1, 1'b0, so, co, eo);
    chk("d3_sum", 64'(so), 64'h3766); chk("d3_cout", 64'(co), 64'd1);
    run_op(16'h1234, 16'h5000, 1'b1, 1'b0, so, co, eo);
    chk("d4_sum", 64'(so), 64'h6234); chk("d4_cout", 64'(co), 64'd0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b1, so, co, eo);
    chk("d5_sum", 64'(so), 64'h9999); chk("d5_cout", 64'(co), 64'd0);
    run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, so, co, eo);
    chk("d6_err", 64'(eo), 64'd1);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, so, co, eo);
    chk("d7_err", 64'(eo), 64'd0); chk("d7_sum", 64'(so), 64'h0002);

    // Backpressure: result held while consumer stalls, new operands ignored.
    bus.out_ready = 1'b0;
    run_op(16'h0456, 16'h0123, 1'b0, 1'b0, bp_sum, bp_cout, eo);
    chk("bp_sum0", 64'(bp_sum), 64'h0579);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0]; bus.a = 16'h9999; bus.b = 16'h9999;
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_sum", 64'(bus.sum), 64'(bp_sum));
      chk("bp_cout", 64'(bus.cout), 64'(bp_cout));
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    op_check("bp_next", 16'h0001, 16'h0001, 1'b0, 1'b0);

    // Asynchronous reset after digit 1 of a run.
    bus.a = 16'h99AA; bus.b = 16'h0000; bus.sub = 1'b0; bus.cin = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_sum", 64'(bus.sum), 64'd0);
    chk("ar_cout", 64'(bus.cout), 64'd0);
    chk("ar_err", 64'(bus.err), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_in_ready", 64'(bus.in_ready), 64'd1);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, so, co, eo);
    chk("ar_next_sum", 64'(so), 64'h0002);

    // Random valid-BCD operands against the model.
    for (int k = 0; k < 60; k++) begin
      ra = '0; rb = '0;
      for (int d = 0; d < N; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      op_check("rnd", ra, rb, 1'($urandom), 1'($urandom));
    end
    // Random operands with one corrupted digit: only err is checked.
    for (int k = 0; k < 10; k++) begin
      ra = '0; rb = '0;
      for (int d = 0; d < N; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      if (k[0]) ra[4*$urandom_range(0, N-1) +: 4] = 4'($urandom_range(10, 15));
      else      rb[4*$urandom_range(0, N-1) +: 4] = 4'($urandom_range(10, 15));
      op_check("rnd_bad", ra, rb, 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
